vga_scan_ctrl: RTL and testbench
================================

VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
  H_DISP 640 visible pixels per line; H_FRONT 16 front porch; H_SYNC 96 sync width; H_BACK 48 back porch (H_TOTAL 800).
  V_DISP 480 visible lines; V_FRONT 10; V_SYNC 2; V_BACK 33 (V_TOTAL 525).
  CELL_SHIFT 4 log2 of cell size in pixels (40x30 cell grid).
REQ-002 Ports SHALL be, one per line: name direction width meaning:
  clk_25 in 1 pixel clock, 25 MHz.
  rst in 1 reset, asynchronous, active-high.
  pixel_xpos out 10 visible column, 0 outside active video.
  pixel_ypos out 10 visible line, 0 outside active video.
  cell_addr out 11 board RAM address = (ypos>>CELL_SHIFT)*40 + (xpos>>CELL_SHIFT).
  rd_en out 1 display read of board RAM this cycle.
  hsync out 1 horizontal sync, active-low, delayed one cycle.
  vsync out 1 vertical sync, active-low, delayed one cycle.
  video_on out 1 active-video flag, delayed one cycle.
  frame_start out 1 one-cycle pulse at h_cnt=0, v_cnt=0.
  wr_req in 1 game logic requests board RAM.
  wr_gnt out 1 game logic owns board RAM.
  wr_done in 1 game logic releases board RAM.
  wr_abort out 1 one-cycle pulse, grant revoked by end of blanking.
  ram_sel out 1 RAM port mux select, 0 display, 1 game logic.

Function
REQ-003 h_cnt SHALL count 0..H_TOTAL-1 and wrap to 0; v_cnt SHALL increment only when h_cnt wraps and wrap 0..V_TOTAL-1.
REQ-004 Active region SHALL be h_cnt<H_DISP and v_cnt<V_DISP; pixel_xpos/ypos/cell_addr/rd_en SHALL be combinational from counters (cycle N).
REQ-005 hsync SHALL be low for h_cnt in [656,751], vsync low for v_cnt in [490,491]; hsync/vsync/video_on SHALL be registered one cycle after counters to align with the downstream registered pixel_data.
REQ-006 cell_addr SHALL use row*32+row*8 (no multiplier), 11-bit result, max 1199; 0 outside active video.
REQ-007 rd_en SHALL equal active region AND NOT ram_sel; ram_sel=1 SHALL never coincide with active region.
REQ-008 Arbiter FSM states: IDLE, GRANT, SPENT.
REQ-009 IDLE->GRANT when wr_req=1 and V_DISP<=v_cnt<=V_TOTAL-2; wr_gnt and ram_sel registered, high from next cycle.
REQ-010 GRANT->SPENT on wr_done=1; wr_gnt drops next cycle.
REQ-011 GRANT->IDLE forced when h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1: wr_gnt drops, wr_abort pulses one cycle; wr_done in the same cycle SHALL take precedence (->SPENT, no abort).
REQ-012 SPENT->IDLE on frame_start; at most one grant per frame.
REQ-013 wr_req during active video or last blank line SHALL be held off, not dropped; granted in next eligible cycle if still asserted.
REQ-014 wr_done outside GRANT SHALL be ignored.

Reset
REQ-015 On rst: h_cnt=v_cnt=0, FSM=IDLE, hsync=vsync=1, video_on=0, wr_gnt=0, wr_abort=0, ram_sel=0, frame_start=0; counting resumes first edge after release.
REQ-016 rst mid-grant SHALL drop wr_gnt immediately (asynchronous) with no wr_abort pulse.

Structure
REQ-017 Timing defaults, H_TOTAL/V_TOTAL, GRID_COLS=40, GRID_ROWS=30 and FSM state encoding SHALL live in shared package vga_pkg.
REQ-018 One sub-module vga_timing_gen (counters, sync, active region) SHALL be instantiated; arbiter FSM and address logic stay in vga_scan_ctrl.

Verification
REQ-019 Free-run after reset 2 frames -> hsync period 800 cycles low 96; vsync period 420000 cycles low 1600; frame_start every 420000.
REQ-020 Counters at (xpos 37, ypos 50) -> cell_addr=3*40+2=122; at (639,479) -> 1199; rd_en=1.
REQ-021 wr_req at v_cnt=100 -> wr_gnt rises cycle after v_cnt reaches 480, h_cnt=0; wr_done 10 cycles later -> wr_gnt low, SPENT until frame_start.
REQ-022 wr_req held through blanking, no wr_done -> wr_abort pulse at v_cnt=524,h_cnt=799 edge, wr_gnt=0, ram_sel=0 before line 0 pixel 0.
REQ-023 wr_done and forced-revoke in same cycle -> no wr_abort, FSM SPENT; second wr_req same frame -> no grant.
REQ-024 rst asserted during GRANT at v_cnt=500 -> wr_gnt/ram_sel 0 immediately, hsync=vsync=1, counters 0 after release.

Source files
------------

// File: rtl/vga_pkg.sv
// ============================================================================
// Module : vga_pkg
// Brief  : Shared 640x480@60 timing defaults, board grid size, arbiter states.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vga_pkg;

  localparam int DEF_H_DISP  = 640;
  localparam int DEF_H_FRONT = 16;
  localparam int DEF_H_SYNC  = 96;
  localparam int DEF_H_BACK  = 48;
  localparam int H_TOTAL     = DEF_H_DISP + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

  localparam int DEF_V_DISP  = 480;
  localparam int DEF_V_FRONT = 10;
  localparam int DEF_V_SYNC  = 2;
  localparam int DEF_V_BACK  = 33;
  localparam int V_TOTAL     = DEF_V_DISP + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int DEF_CELL_SHIFT = 4;
  localparam int GRID_COLS      = 40;
  localparam int GRID_ROWS      = 30;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_SPENT = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module : vga_timing_gen
// Brief  : Raster counters, registered sync/video_on and frame markers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_DISP  = DEF_H_DISP,
  parameter int H_FRONT = DEF_H_FRONT,
  parameter int H_SYNC  = DEF_H_SYNC,
  parameter int H_BACK  = DEF_H_BACK,
  parameter int V_DISP  = DEF_V_DISP,
  parameter int V_FRONT = DEF_V_FRONT,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BACK  = DEF_V_BACK
) (
  input  logic       clk_25,
  input  logic       rst,
  output logic [9:0] o_h_cnt,
  output logic [9:0] o_v_cnt,
  output logic       o_active,
  output logic       o_frame_last,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_video_on,
  output logic       o_frame_start
);

  localparam int         H_TOT  = H_DISP + H_FRONT + H_SYNC + H_BACK;
  localparam int         V_TOT  = V_DISP + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISP);
  localparam logic [9:0] V_VIS  = 10'(V_DISP);
  localparam logic [9:0] HS_BEG = 10'(H_DISP + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_DISP + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_DISP + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_DISP + V_FRONT + V_SYNC - 1);

  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_video_on;
  logic       r_frame_start;
  logic       w_h_wrap;
  logic       w_v_wrap;
  logic       w_active;

  assign w_h_wrap = (r_h_cnt == H_LAST);
  assign w_v_wrap = (r_v_cnt == V_LAST);
  assign w_active = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);

  // Sync and video_on lag the counters by one cycle to line up with registered pixel data.
  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_video_on    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + 10'd1;
      if (w_h_wrap) begin
        r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 10'd1;
      end
      r_hsync       <= !((r_h_cnt >= HS_BEG) && (r_h_cnt <= HS_END));
      r_vsync       <= !((r_v_cnt >= VS_BEG) && (r_v_cnt <= VS_END));
      r_video_on    <= w_active;
      r_frame_start <= w_h_wrap && w_v_wrap;
    end
  end

  assign o_h_cnt       = r_h_cnt;
  assign o_v_cnt       = r_v_cnt;
  assign o_active      = w_active;
  assign o_frame_last  = w_h_wrap && w_v_wrap;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_video_on    = r_video_on;
  assign o_frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: rtl/vga_scan_ctrl.sv
// ============================================================================
// Module : vga_scan_ctrl
// Brief  : VGA scan with board-RAM cell addressing and blanking-time arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int H_DISP     = DEF_H_DISP,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_DISP     = DEF_V_DISP,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int CELL_SHIFT = DEF_CELL_SHIFT
) (
  input  logic        clk_25,
  input  logic        rst,
  output logic [9:0]  pixel_xpos,
  output logic [9:0]  pixel_ypos,
  output logic [10:0] cell_addr,
  output logic        rd_en,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        frame_start,
  input  logic        wr_req,
  output logic        wr_gnt,
  input  logic        wr_done,
  output logic        wr_abort,
  output logic        ram_sel
);

  localparam int         V_TOT   = V_DISP + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] ELIG_LO = 10'(V_DISP);
  localparam logic [9:0] ELIG_HI = 10'(V_TOT - 2);

  logic [9:0]  w_h_cnt;
  logic [9:0]  w_v_cnt;
  logic        w_active;
  logic        w_frame_last;
  logic        w_eligible;
  logic [9:0]  w_col;
  logic [9:0]  w_row;
  logic [10:0] w_row_ext;
  logic [10:0] w_addr;
  arb_state_t  r_state;
  logic        r_gnt;
  logic        r_abort;

  vga_timing_gen #(
    .H_DISP (H_DISP),
    .H_FRONT(H_FRONT),
    .H_SYNC (H_SYNC),
    .H_BACK (H_BACK),
    .V_DISP (V_DISP),
    .V_FRONT(V_FRONT),
    .V_SYNC (V_SYNC),
    .V_BACK (V_BACK)
  ) u_timing (
    .clk_25       (clk_25),
    .rst          (rst),
    .o_h_cnt      (w_h_cnt),
    .o_v_cnt      (w_v_cnt),
    .o_active     (w_active),
    .o_frame_last (w_frame_last),
    .o_hsync      (hsync),
    .o_vsync      (vsync),
    .o_video_on   (video_on),
    .o_frame_start(frame_start)
  );

  assign pixel_xpos = w_active ? w_h_cnt : '0;
  assign pixel_ypos = w_active ? w_v_cnt : '0;

  // row*40 built as row*32 + row*8 to keep the address path adder-only.
  assign w_col     = pixel_xpos >> CELL_SHIFT;
  assign w_row     = pixel_ypos >> CELL_SHIFT;
  assign w_row_ext = {1'b0, w_row};
  assign w_addr    = (w_row_ext << 5) + (w_row_ext << 3) + {1'b0, w_col};
  assign cell_addr = w_active ? w_addr : '0;

  // The final blank line is excluded so a fresh grant always has room before the forced revoke.
  assign w_eligible = (w_v_cnt >= ELIG_LO) && (w_v_cnt <= ELIG_HI);

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_gnt   <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_abort <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (wr_req && w_eligible) begin
            r_state <= ARB_GRANT;
            r_gnt   <= 1'b1;
          end
        end
        ARB_GRANT: begin
          if (wr_done) begin
            r_state <= ARB_SPENT;
            r_gnt   <= 1'b0;
          end else if (w_frame_last) begin
            r_state <= ARB_IDLE;
            r_gnt   <= 1'b0;
            r_abort <= 1'b1;
          end
        end
        ARB_SPENT: begin
          if (frame_start) begin
            r_state <= ARB_IDLE;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_gnt   <= 1'b0;
        end
      endcase
    end
  end

  assign wr_gnt   = r_gnt;
  assign ram_sel  = r_gnt;
  assign wr_abort = r_abort;
  assign rd_en    = w_active && !r_gnt;

endmodule

`default_nettype wire

// File: tb/tb_vga_scan_ctrl.sv
// ============================================================================
// Module : tb_vga_scan_ctrl
// Brief  : Self-checking bench for vga_scan_ctrl on a reduced raster.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vga_scan_ctrl;

  // Reduced raster keeps the 40x30 cell grid (CELL_SHIFT=1) at a fraction of the cycles.
  localparam int HD = 80, HF = 2, HS = 4, HB = 2, HT = HD + HF + HS + HB;
  localparam int VD = 60, VF = 2, VS = 2, VB = 3, VT = VD + VF + VS + VB;
  localparam int SH = 1;
  localparam int FRAME = HT * VT;

  logic        clk_25 = 1'b0;
  logic        rst = 1'b1;
  logic        wr_req = 1'b0;
  logic        wr_done = 1'b0;
  logic [9:0]  pixel_xpos, pixel_ypos;
  logic [10:0] cell_addr;
  logic        rd_en, hsync, vsync, video_on, frame_start, wr_gnt, wr_abort, ram_sel;

  int total = 0;
  int bad = 0;

  always #20 clk_25 = ~clk_25;

  vga_scan_ctrl #(
    .H_DISP(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISP(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CELL_SHIFT(SH)
  ) dut (
    .clk_25(clk_25), .rst(rst),
    .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos), .cell_addr(cell_addr),
    .rd_en(rd_en), .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .frame_start(frame_start), .wr_req(wr_req), .wr_gnt(wr_gnt),
    .wr_done(wr_done), .wr_abort(wr_abort), .ram_sel(ram_sel)
  );

  // Reference: cycles since reset give raster position; ownership tracked as two flags.
  int cyc = 0;
  bit m_own = 1'b0;
  bit m_used = 1'b0;
  bit m_abort = 1'b0;

  function automatic int hh(input int c); return c % HT; endfunction
  function automatic int vv(input int c); return (c / HT) % VT; endfunction
  function automatic bit act(input int c); return (hh(c) < HD) && (vv(c) < VD); endfunction

  always @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      cyc <= 0; m_own <= 1'b0; m_used <= 1'b0; m_abort <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      m_abort <= 1'b0;
      if (cyc > 0 && cyc % FRAME == 0) m_used <= 1'b0;
      else if (m_own) begin
        if (wr_done) begin m_own <= 1'b0; m_used <= 1'b1; end
        else if (cyc % FRAME == FRAME - 1) begin m_own <= 1'b0; m_abort <= 1'b1; end
      end else if (!m_used && wr_req && vv(cyc) >= VD && vv(cyc) <= VT - 2) m_own <= 1'b1;
    end
  end

  function automatic logic [38:0] expect_vec(input int c, input bit own, input bit ab);
    int x, y;
    bit a;
    a = act(c);
    x = a ? hh(c) : 0;
    y = a ? vv(c) : 0;
    return {10'(x), 10'(y), 11'(a ? (y >> SH) * 40 + (x >> SH) : 0), a && !own,
            (c == 0) ? 1'b1 : !(hh(c-1) >= HD + HF && hh(c-1) < HD + HF + HS),
            (c == 0) ? 1'b1 : !(vv(c-1) >= VD + VF && vv(c-1) < VD + VF + VS),
            (c == 0) ? 1'b0 : act(c-1),
            (c > 0) && (c % FRAME == 0), own, ab, own};
  endfunction

  task automatic tick();
    logic [38:0] got, want;
    @(negedge clk_25);
    got  = {pixel_xpos, pixel_ypos, cell_addr, rd_en, hsync, vsync, video_on,
            frame_start, wr_gnt, wr_abort, ram_sel};
    want = expect_vec(cyc, m_own, m_abort);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL cycle_compare cyc=%0d got=%h want=%h", cyc, got, want);
    end
  endtask

  task automatic wait_pos(input int x, input int y, input string tag);
    int n = 0;
    while (!(hh(cyc) == x && vv(cyc) == y) && n < 2 * FRAME) begin tick(); n++; end
    total++;
    if (n >= 2 * FRAME) begin bad++; $display("FAIL %s timeout got=%0d want<%0d", tag, n, 2 * FRAME); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if ({hsync, vsync, video_on, wr_gnt, wr_abort, ram_sel, frame_start, pixel_xpos} !== {7'b1100000, 10'd0}) begin
      bad++;
      $display("FAIL reset_state got=%b_%0d want=1100000_0",
               {hsync, vsync, video_on, wr_gnt, wr_abort, ram_sel, frame_start}, pixel_xpos);
    end
    rst = 1'b0;
    tick();
    total++;
    if (pixel_xpos !== 10'd1) begin bad++; $display("FAIL reset_resume got=%0d want=1", pixel_xpos); end
  endtask

  task automatic test_free_run();
    int hs_low = 0, vs_low = 0, fs = 0, hf1 = -1, hf2 = -1, vf1 = -1, vf2 = -1;
    logic p_hs = hsync, p_vs = vsync;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (frame_start) fs++;
      if (p_hs && !hsync) begin if (hf1 < 0) hf1 = i; else if (hf2 < 0) hf2 = i; end
      if (p_vs && !vsync) begin if (vf1 < 0) vf1 = i; else if (vf2 < 0) vf2 = i; end
      p_hs = hsync; p_vs = vsync;
    end
    total++; if (hs_low != 2 * VT * HS) begin bad++; $display("FAIL hsync_low got=%0d want=%0d", hs_low, 2 * VT * HS); end
    total++; if (vs_low != 2 * VS * HT) begin bad++; $display("FAIL vsync_low got=%0d want=%0d", vs_low, 2 * VS * HT); end
    total++; if (fs != 2) begin bad++; $display("FAIL frame_start_count got=%0d want=2", fs); end
    total++; if (hf2 - hf1 != HT) begin bad++; $display("FAIL hsync_period got=%0d want=%0d", hf2 - hf1, HT); end
    total++; if (vf2 - vf1 != FRAME) begin bad++; $display("FAIL vsync_period got=%0d want=%0d", vf2 - vf1, FRAME); end
  endtask

  task automatic test_cell_addr();
    int x, y;
    wait_pos(37, 50, "cell_a");
    total++;
    if (cell_addr !== 11'd1018 || rd_en !== 1'b1) begin
      bad++; $display("FAIL cell_37_50 got=%0d/%b want=1018/1", cell_addr, rd_en);
    end
    wait_pos(HD - 1, VD - 1, "cell_b");
    total++;
    if (cell_addr !== 11'd1199 || rd_en !== 1'b1) begin
      bad++; $display("FAIL cell_last got=%0d/%b want=1199/1", cell_addr, rd_en);
    end
    x = $urandom_range(0, HD - 1);
    y = $urandom_range(0, VD - 1);
    wait_pos(x, y, "cell_c");
    total++;
    if (cell_addr !== 11'((y >> SH) * 40 + (x >> SH))) begin
      bad++; $display("FAIL cell_random x=%0d y=%0d got=%0d want=%0d", x, y, cell_addr, (y >> SH) * 40 + (x >> SH));
    end
  endtask

  task automatic test_grant_done();
    int n = 0, again = 0;
    wait_pos(0, 20, "grant_wait");
    wr_req = 1'b1;
    while (wr_gnt !== 1'b1 && n < 2 * FRAME) begin tick(); n++; end
    total++;
    if (n != (VD - 20) * HT + 1) begin bad++; $display("FAIL grant_latency got=%0d want=%0d", n, (VD - 20) * HT + 1); end
    wr_req = 1'b0;
    repeat (9) tick();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    total++;
    if (wr_gnt !== 1'b0 || ram_sel !== 1'b0) begin bad++; $display("FAIL done_release got=%b%b want=00", wr_gnt, ram_sel); end
    wr_req = 1'b1;
    n = 0;
    while (!(cyc % FRAME == 0) && n < 2 * FRAME) begin tick(); n++; if (wr_gnt) again++; end
    wr_req = 1'b0;
    total++;
    if (again != 0) begin bad++; $display("FAIL second_grant got=%0d want=0", again); end
  endtask

  task automatic test_abort();
    int n = 0;
    wr_req = 1'b1;
    while (wr_abort !== 1'b1 && n < 2 * FRAME) begin tick(); n++; end
    wr_req = 1'b0;
    total++;
    if (n != FRAME) begin bad++; $display("FAIL abort_time got=%0d want=%0d", n, FRAME); end
    total++;
    if ({frame_start, wr_gnt, ram_sel} !== 3'b100) begin
      bad++; $display("FAIL abort_state got=%b want=100", {frame_start, wr_gnt, ram_sel});
    end
    tick();
    total++;
    if (wr_abort !== 1'b0) begin bad++; $display("FAIL abort_width got=%b want=0", wr_abort); end
  endtask

  task automatic test_done_vs_revoke();
    wr_req = 1'b1;
    wait_pos(HT - 1, VT - 1, "revoke_wait");
    total++;
    if (wr_gnt !== 1'b1) begin bad++; $display("FAIL revoke_pre got=%b want=1", wr_gnt); end
    wr_done = 1'b1;
    wr_req = 1'b0;
    tick();
    wr_done = 1'b0;
    total++;
    if ({wr_abort, wr_gnt} !== 2'b00) begin bad++; $display("FAIL done_wins got=%b want=00", {wr_abort, wr_gnt}); end
  endtask

  task automatic test_random();
    for (int i = 0; i < FRAME; i++) begin
      wr_req  = ($urandom_range(0, 7) == 0);
      wr_done = ($urandom_range(0, 15) == 0);
      tick();
    end
    wr_req = 1'b0;
    wr_done = 1'b0;
  endtask

  task automatic test_rst_mid_grant();
    wr_req = 1'b1;
    wait_pos(0, VD + 3, "rst_wait");
    total++;
    if (wr_gnt !== 1'b1) begin bad++; $display("FAIL rst_pre_grant got=%b want=1", wr_gnt); end
    rst = 1'b1;
    #1;
    total++;
    if ({wr_gnt, ram_sel, wr_abort, hsync, vsync} !== 5'b00011) begin
      bad++; $display("FAIL rst_async got=%b want=00011", {wr_gnt, ram_sel, wr_abort, hsync, vsync});
    end
    wr_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    total++;
    if ({pixel_xpos, pixel_ypos} !== {10'd1, 10'd0}) begin
      bad++; $display("FAIL rst_restart got=%0d,%0d want=1,0", pixel_xpos, pixel_ypos);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_cell_addr();
    test_grant_done();
    test_abort();
    test_done_vs_revoke();
    test_random();
    test_rst_mid_grant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
